// File: rtl/key_seq_tx.sv
// Streams the 19-byte unlock key sequence over a valid/ready bus and monitors the checker response.
// Optional KEY_SEQ_TX_ABORT_EN: abort the sequence on the first rejected byte.
module key_seq_tx #(
    parameter int LEN = 19,
    parameter int GAP = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [7:0]     key,
    output logic           key_valid,
    input  logic           key_ready,
    input  logic [LEN-1:0] unlock,
    output logic           busy,
    output logic [4:0]     idx,
    output logic           done,
    output logic           mismatch
);

    // state | meaning
    // IDLE  | waiting for start
    // SEND  | offering ROM[idx] on key
    // GAP   | idle cycles after an accepted byte
    // FIN   | one-cycle done pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAPS = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] gap_cnt;
    logic       hs;
    logic       bad;
    logic       last;

    function automatic logic [7:0] rom_byte(input logic [4:0] i);
        case (i)
            5'd0:    rom_byte = 8'd83;
            5'd1:    rom_byte = 8'd52;
            5'd2:    rom_byte = 8'd116;
            5'd3:    rom_byte = 8'd95;
            5'd4:    rom_byte = 8'd115;
            5'd5:    rom_byte = 8'd48;
            5'd6:    rom_byte = 8'd49;
            5'd7:    rom_byte = 8'd118;
            5'd8:    rom_byte = 8'd101;
            5'd9:    rom_byte = 8'd82;
            5'd10:   rom_byte = 8'd95;
            5'd11:   rom_byte = 8'd105;
            5'd12:   rom_byte = 8'd53;
            5'd13:   rom_byte = 8'd95;
            5'd14:   rom_byte = 8'd71;
            5'd15:   rom_byte = 8'd114;
            5'd16:   rom_byte = 8'd57;
            5'd17:   rom_byte = 8'd97;
            5'd18:   rom_byte = 8'd55;
            default: rom_byte = 8'd0;
        endcase
    endfunction

    assign hs   = (state == SEND) && key_ready;
    assign bad  = !unlock[idx];
    assign last = (idx == 5'(LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = SEND;
            end
            SEND: begin
                if (hs) begin
`ifdef KEY_SEQ_TX_ABORT_EN
                    if (bad)           state_nxt = IDLE;
                    else if (last)     state_nxt = FIN;
                    else if (GAP > 0)  state_nxt = GAPS;
                    else               state_nxt = SEND;
`else
                    if (last)          state_nxt = FIN;
                    else if (GAP > 0)  state_nxt = GAPS;
                    else               state_nxt = SEND;
`endif
                end
            end
            GAPS: begin
                if (gap_cnt <= 4'd1) state_nxt = SEND;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_valid = (state == SEND);
        key       = key_valid ? rom_byte(idx) : 8'd0;
        busy      = (state == SEND) || (state == GAPS);
        done      = (state == FIN);
    end

    // idx advances only on an accepted non-final byte; on abort it keeps the failing index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 5'd0;
            mismatch <= 1'b0;
            gap_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= 5'd0;
                        mismatch <= 1'b0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (bad) mismatch <= 1'b1;
`ifdef KEY_SEQ_TX_ABORT_EN
                        if (!last && !bad) idx <= idx + 5'd1;
`else
                        if (!last) idx <= idx + 5'd1;
`endif
                        gap_cnt <= 4'(GAP);
                    end
                end
                GAPS: begin
                    gap_cnt <= gap_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_seq_tx.sv
// Directed bench for key_seq_tx: two instances (GAP=0 and GAP=2) driven by a behavioural key checker.
module tb_key_seq_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom [0:18] = '{8'd83, 8'd52, 8'd116, 8'd95, 8'd115, 8'd48, 8'd49, 8'd118,
                               8'd101, 8'd82, 8'd95, 8'd105, 8'd53, 8'd95, 8'd71, 8'd114,
                               8'd57, 8'd97, 8'd55};

    int checks = 0;
    int errors = 0;

    logic        start0 = 1'b0, ready0 = 1'b1, stub5 = 1'b0;
    logic [7:0]  key0;
    logic        key_valid0, busy0, done0, mismatch0;
    logic [4:0]  idx0;
    logic [18:0] unlock0;

    logic        start2 = 1'b0, ready2 = 1'b1;
    logic [7:0]  key2;
    logic        key_valid2, busy2, done2, mismatch2;
    logic [4:0]  idx2;
    logic [18:0] unlock2;

    function automatic logic [18:0] checker_fn(input logic [7:0] k, input logic v);
        logic [18:0] u;
        u = '0;
        for (int i = 0; i < 19; i++) u[i] = v && (k == rom[i]);
        return u;
    endfunction

    assign unlock0 = checker_fn(key0, key_valid0) & (stub5 ? 19'h7FFDF : 19'h7FFFF);
    assign unlock2 = checker_fn(key2, key_valid2);

    key_seq_tx #(.LEN(19), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .key(key0), .key_valid(key_valid0),
        .key_ready(ready0), .unlock(unlock0), .busy(busy0), .idx(idx0), .done(done0),
        .mismatch(mismatch0)
    );

    key_seq_tx #(.LEN(19), .GAP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .key(key2), .key_valid(key_valid2),
        .key_ready(ready2), .unlock(unlock2), .busy(busy2), .idx(idx2), .done(done2),
        .mismatch(mismatch2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
    endtask

    task automatic check_zero0(input string name);
        checks++;
        if ({key0, key_valid0, busy0, idx0, done0, mismatch0} !== 17'd0) begin
            errors++;
            $display("FAIL %s: key=%0d valid=%0b busy=%0b idx=%0d done=%0b mismatch=%0b, required all 0",
                     name, key0, key_valid0, busy0, idx0, done0, mismatch0);
        end
    endtask

    task automatic check_byte0(input string name, input int i);
        checks++;
        if (key_valid0 !== 1'b1 || key0 !== rom[i] || idx0 !== 5'(i) || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL %s[%0d]: valid=%0b key=%0d idx=%0d busy=%0b, required valid=1 key=%0d idx=%0d busy=1",
                     name, i, key_valid0, key0, idx0, busy0, rom[i], i);
        end
    endtask

    task automatic check_done0(input string name, input logic exp_mm);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || key_valid0 !== 1'b0 || mismatch0 !== exp_mm) begin
            errors++;
            $display("FAIL %s: done=%0b busy=%0b valid=%0b mismatch=%0b, required done=1 busy=0 valid=0 mismatch=%0b",
                     name, done0, busy0, key_valid0, mismatch0, exp_mm);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        check_zero0("reset0");
        checks++;
        if ({key2, key_valid2, busy2, idx2, done2, mismatch2} !== 17'd0) begin
            errors++;
            $display("FAIL reset2: key=%0d valid=%0b busy=%0b idx=%0d, required all 0",
                     key2, key_valid2, busy2, idx2);
        end
        rst_n = 1'b1;
        step();
        check_zero0("idle_after_reset");
    endtask

    task automatic test_full_stream;
        ready0 = 1'b1;
        pulse_start0();
        for (int i = 0; i < 19; i++) begin
            check_byte0("stream", i);
            step();
        end
        check_done0("stream_done", 1'b0);
        step();
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL stream_done_pulse: done=%0b busy=%0b, required 0 0", done0, busy0);
        end
    endtask

    task automatic test_stall;
        ready0 = 1'b1;
        pulse_start0();
        for (int i = 0; i < 19; i++) begin
            if (i == 3) begin
                ready0 = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    check_byte0("stall_hold", 3);
                    step();
                end
                ready0 = 1'b1;
            end
            check_byte0("stall", i);
            step();
        end
        check_done0("stall_done", 1'b0);
        step();
    endtask

    task automatic test_gap;
        ready2 = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 19; i++) begin
            checks++;
            if (key_valid2 !== 1'b1 || key2 !== rom[i] || idx2 !== 5'(i)) begin
                errors++;
                $display("FAIL gap_byte[%0d]: valid=%0b key=%0d idx=%0d, required 1 %0d %0d",
                         i, key_valid2, key2, idx2, rom[i], i);
            end
            step();
            if (i < 18) begin
                for (int g = 0; g < 2; g++) begin
                    checks++;
                    if (key_valid2 !== 1'b0 || key2 !== 8'd0 || busy2 !== 1'b1 || done2 !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_idle[%0d.%0d]: valid=%0b key=%0d busy=%0b done=%0b, required 0 0 1 0",
                                 i, g, key_valid2, key2, busy2, done2);
                    end
                    step();
                end
            end
        end
        checks++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || mismatch2 !== 1'b0) begin
            errors++;
            $display("FAIL gap_done: done=%0b busy=%0b mismatch=%0b, required 1 0 0", done2, busy2, mismatch2);
        end
        step();
    endtask

    task automatic test_mismatch;
        ready0 = 1'b1;
        stub5  = 1'b1;
        pulse_start0();
        for (int i = 0; i < 6; i++) begin
            check_byte0("mm_byte", i);
            checks++;
            if (mismatch0 !== 1'b0) begin
                errors++;
                $display("FAIL mm_early[%0d]: mismatch=%0b, required 0", i, mismatch0);
            end
            step();
        end
`ifdef KEY_SEQ_TX_ABORT_EN
        checks++;
        if (mismatch0 !== 1'b1 || busy0 !== 1'b0 || idx0 !== 5'd5 || key_valid0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL mm_abort: mismatch=%0b busy=%0b idx=%0d valid=%0b done=%0b, required 1 0 5 0 0",
                     mismatch0, busy0, idx0, key_valid0, done0);
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (done0 !== 1'b0 || key_valid0 !== 1'b0 || idx0 !== 5'd5 || mismatch0 !== 1'b1) begin
                errors++;
                $display("FAIL mm_abort_idle[%0d]: done=%0b valid=%0b idx=%0d mismatch=%0b, required 0 0 5 1",
                         c, done0, key_valid0, idx0, mismatch0);
            end
            step();
        end
`else
        for (int i = 6; i < 19; i++) begin
            check_byte0("mm_rest", i);
            checks++;
            if (mismatch0 !== 1'b1) begin
                errors++;
                $display("FAIL mm_sticky[%0d]: mismatch=%0b, required 1", i, mismatch0);
            end
            step();
        end
        check_done0("mm_done", 1'b1);
        step();
`endif
        stub5 = 1'b0;
    endtask

    task automatic test_back_to_back;
        ready0 = 1'b1;
        start0 = 1'b1;
        step();
        for (int i = 0; i < 19; i++) begin
            check_byte0("b2b", i);
            if (i == 0) begin
                checks++;
                if (mismatch0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_mm_clear: mismatch=%0b, required 0", mismatch0);
                end
            end
            step();
        end
        check_done0("b2b_done", 1'b0);
        step();
        checks++;
        if (busy0 !== 1'b0 || key_valid0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%0b valid=%0b done=%0b, required 0 0 0", busy0, key_valid0, done0);
        end
        step();
        start0 = 1'b0;
        check_byte0("b2b_restart", 0);
        step();
        check_byte0("b2b_restart", 1);
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        pulse_start0();
        for (int i = 0; i < 10; i++) step();
        check_byte0("mid_before_reset", 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero0("mid_async_reset");
        step();
        check_zero0("mid_reset_held");
        #2;
        rst_n = 1'b1;
        step();
        check_zero0("mid_after_release");
        pulse_start0();
        check_byte0("mid_restart", 0);
        step();
        check_byte0("mid_restart", 1);
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_stall();
        test_gap();
        test_mismatch();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
